// File: rtl/spi_byte_if.sv
// Byte handshake between the command processor (master) and the SPI byte engine (slave).
// The engine sees the slave modport; the command processor or a bench drives the master side.
interface spi_byte_if;
  logic [7:0] i_tx_byte;
  logic       i_tx_dv;
  logic       o_tx_ready;
  logic [7:0] o_rx_byte;
  logic       o_rx_dv;

  modport master (
    output i_tx_byte, i_tx_dv,
    input  o_tx_ready, o_rx_byte, o_rx_dv
  );

  modport slave (
    input  i_tx_byte, i_tx_dv,
    output o_tx_ready, o_rx_byte, o_rx_dv
  );
endinterface

// File: rtl/spi_byte_master.sv
// Byte-level SPI master: shifts one byte out MSB-first on MOSI while sampling MISO,
// in any of the four SPI modes, with a single-cycle completion pulse.
module spi_byte_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 4
) (
  input  logic      clk,
  input  logic      rst,
  spi_byte_if.slave bus,
  output logic      o_sclk,
  output logic      o_mosi,
  input  logic      i_miso
);
  localparam logic       CPOL      = ((SPI_MODE / 2) % 2) == 1;
  localparam logic       CPHA      = (SPI_MODE % 2) == 1;
  localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

  state_t     r_state,    w_state;
  logic [7:0] r_tx_shift, w_tx_shift;
  logic [7:0] r_rx_shift, w_rx_shift;
  logic [7:0] r_rx_byte,  w_rx_byte;
  logic [4:0] r_edge_cnt, w_edge_cnt;
  logic [7:0] r_half_cnt, w_half_cnt;
  logic       r_sclk,     w_sclk;
  logic       r_mosi,     w_mosi;
  logic       r_tx_ready, w_tx_ready;
  logic       r_rx_dv,    w_rx_dv;
  logic       w_leading;

  // Edges are counted down from 16, so an even remaining count means the next edge is odd (leading).
  assign w_leading = ~r_edge_cnt[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tx_shift <= 8'h00;
      r_rx_shift <= 8'h00;
      r_rx_byte  <= 8'h00;
      r_edge_cnt <= 5'd0;
      r_half_cnt <= 8'd0;
      r_sclk     <= CPOL;
      r_mosi     <= 1'b0;
      r_tx_ready <= 1'b1;
      r_rx_dv    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tx_shift <= w_tx_shift;
      r_rx_shift <= w_rx_shift;
      r_rx_byte  <= w_rx_byte;
      r_edge_cnt <= w_edge_cnt;
      r_half_cnt <= w_half_cnt;
      r_sclk     <= w_sclk;
      r_mosi     <= w_mosi;
      r_tx_ready <= w_tx_ready;
      r_rx_dv    <= w_rx_dv;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_tx_shift = r_tx_shift;
    w_rx_shift = r_rx_shift;
    w_rx_byte  = r_rx_byte;
    w_edge_cnt = r_edge_cnt;
    w_half_cnt = r_half_cnt;
    w_sclk     = r_sclk;
    w_mosi     = r_mosi;
    w_tx_ready = r_tx_ready;
    w_rx_dv    = 1'b0;

    unique case (r_state)
      // DONE keeps o_tx_ready high, so a new byte can be taken in the same cycle as o_rx_dv.
      S_IDLE, S_DONE: begin
        w_state = S_IDLE;
        if (bus.i_tx_dv) begin
          w_state    = S_SHIFT;
          w_tx_shift = bus.i_tx_byte;
          w_rx_shift = 8'h00;
          w_edge_cnt = 5'd16;
          w_half_cnt = 8'd1;
          w_tx_ready = 1'b0;
          if (!CPHA) begin
            w_mosi = bus.i_tx_byte[7];
          end
        end
      end
      S_SHIFT: begin
        if (r_edge_cnt == 5'd0) begin
          w_state    = S_DONE;
          w_rx_byte  = r_rx_shift;
          w_rx_dv    = 1'b1;
          w_tx_ready = 1'b1;
          w_mosi     = 1'b0;
        end else if (r_half_cnt == HALF_LAST) begin
          w_half_cnt = 8'd0;
          w_sclk     = ~r_sclk;
          w_edge_cnt = r_edge_cnt - 5'd1;
          if (w_leading == CPHA) begin
            // Drive edge; in CPHA=0 bit7 is already out, and edge 16 drives nothing.
            if (CPHA) begin
              w_mosi     = r_tx_shift[7];
              w_tx_shift = {r_tx_shift[6:0], 1'b0};
            end else if (r_edge_cnt != 5'd1) begin
              w_mosi     = r_tx_shift[6];
              w_tx_shift = {r_tx_shift[6:0], 1'b0};
            end
          end else begin
            w_rx_shift = {r_rx_shift[6:0], i_miso};
          end
        end else begin
          w_half_cnt = r_half_cnt + 8'd1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign o_sclk         = r_sclk;
  assign o_mosi         = r_mosi;
  assign bus.o_tx_ready = r_tx_ready;
  assign bus.o_rx_byte  = r_rx_byte;
  assign bus.o_rx_dv    = r_rx_dv;
endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: three instances (modes 0, 1, 3) at two clocks per half-bit.
module tb_spi_byte_master;
  localparam int H = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0 = mode 0 (MISO looped to MOSI), 1 = mode 1 (slave model), 2 = mode 3 (MISO tied 1)
  logic [2:0] dv;
  logic [7:0] txb;
  logic       miso1;
  logic       sclk0, sclk1, sclk3, mosi0, mosi1, mosi3;

  spi_byte_if if0 ();
  spi_byte_if if1 ();
  spi_byte_if if3 ();

  assign if0.i_tx_dv   = dv[0];
  assign if1.i_tx_dv   = dv[1];
  assign if3.i_tx_dv   = dv[2];
  assign if0.i_tx_byte = txb;
  assign if1.i_tx_byte = txb;
  assign if3.i_tx_byte = txb;

  spi_byte_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(H)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave), .o_sclk(sclk0), .o_mosi(mosi0), .i_miso(mosi0));
  spi_byte_master #(.SPI_MODE(1), .CLKS_PER_HALF_BIT(H)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .o_sclk(sclk1), .o_mosi(mosi1), .i_miso(miso1));
  spi_byte_master #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(H)) u3 (
    .clk(clk), .rst(rst), .bus(if3.slave), .o_sclk(sclk3), .o_mosi(mosi3), .i_miso(1'b1));

  wire [2:0] sclk_v  = {sclk3, sclk1, sclk0};
  wire [2:0] mosi_v  = {mosi3, mosi1, mosi0};
  wire [2:0] ready_v = {if3.o_tx_ready, if1.o_tx_ready, if0.o_tx_ready};
  wire [2:0] rxdv_v  = {if3.o_rx_dv, if1.o_rx_dv, if0.o_rx_dv};
  logic [7:0] rxb_v [3];
  assign rxb_v[0] = if0.o_rx_byte;
  assign rxb_v[1] = if1.o_rx_byte;
  assign rxb_v[2] = if3.o_rx_byte;

  // Mode-1 slave: presents the next bit of 8'h5A after each rising (leading) SCLK edge.
  logic [7:0] slv_byte = 8'h5A;
  logic [2:0] sidx     = 3'd0;
  logic       sclk1_d  = 1'b0;
  initial miso1 = 1'b0;
  always @(posedge clk) begin
    if (if1.o_tx_ready) begin
      sidx <= 3'd0;
    end else if (sclk1 && !sclk1_d) begin
      miso1 <= slv_byte[3'd7 - sidx];
      sidx  <= sidx + 3'd1;
    end
    sclk1_d <= sclk1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input int s, input string tag);
    logic cpol;
    cpol = (s == 2);
    chk1($sformatf("%s_ready s%0d", tag, s), ready_v[s], 1'b1);
    chk1($sformatf("%s_rxdv s%0d", tag, s), rxdv_v[s], 1'b0);
    chk1($sformatf("%s_sclk s%0d", tag, s), sclk_v[s], cpol);
    chk1($sformatf("%s_mosi s%0d", tag, s), mosi_v[s], 1'b0);
  endtask

  // Issues i_tx_dv in the current cycle T, checks every busy cycle, and returns in the DONE cycle.
  task automatic xfer(input int s, input logic [7:0] b, input logic [7:0] exp_rx,
                      input int inject_at, output int done_cyc);
    logic [7:0] cap;
    logic       mosi_or;
    logic       cpol;
    logic       cpha;
    logic       exp_sclk;
    int         k;
    cap     = 8'h00;
    mosi_or = 1'b0;
    cpol    = (s == 2);
    cpha    = (s != 0);
    txb   = b;
    dv[s] = 1'b1;
    tick();
    for (int n = 1; n <= 16 * H; n++) begin
      dv[s] = (n == inject_at);
      if (n == inject_at) txb = 8'h77;
      k        = n / H;
      exp_sclk = cpol ^ (k % 2 == 1);
      chk1($sformatf("busy_ready s%0d n%0d", s, n), ready_v[s], 1'b0);
      chk1($sformatf("busy_rxdv s%0d n%0d", s, n), rxdv_v[s], 1'b0);
      chk1($sformatf("sclk s%0d n%0d", s, n), sclk_v[s], exp_sclk);
      mosi_or = mosi_or | mosi_v[s];
      if ((n % H == 0) && ((k % 2 == 1) != cpha)) cap = {cap[6:0], mosi_v[s]};
      tick();
    end
    dv[s] = 1'b0;
    done_cyc = cyc;
    chk1($sformatf("done_rxdv s%0d", s), rxdv_v[s], 1'b1);
    chk8($sformatf("done_rxbyte s%0d", s), rxb_v[s], exp_rx);
    chk1($sformatf("done_ready s%0d", s), ready_v[s], 1'b1);
    chk1($sformatf("done_sclk s%0d", s), sclk_v[s], cpol);
    chk8($sformatf("mosi_pattern s%0d", s), cap, b);
    chk1($sformatf("mosi_any s%0d", s), mosi_or, |b);
    $display("xfer s%0d tx=%h rx=%h mosi=%h done@%0d", s, b, rxb_v[s], cap, done_cyc);
  endtask

  initial begin
    int d, d1, d2, d3;
    dv  = 3'b000;
    txb = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      idle_chk(s, "reset");
      chk8($sformatf("reset_rxbyte s%0d", s), rxb_v[s], 8'h00);
    end

    xfer(0, 8'hA5, 8'hA5, 0, d);
    tick();
    idle_chk(0, "after_a5");

    xfer(2, 8'h3C, 8'hFF, 0, d);
    tick();
    idle_chk(2, "after_3c");

    xfer(1, 8'h00, 8'h5A, 0, d);
    tick();
    idle_chk(1, "after_00");

    xfer(0, 8'h01, 8'h01, 0, d1);
    xfer(0, 8'h20, 8'h20, 0, d2);
    xfer(0, 8'hFF, 8'hFF, 0, d3);
    chki("b2b_gap12", d2 - d1, 16 * H + 1);
    chki("b2b_gap23", d3 - d2, 16 * H + 1);
    tick();
    idle_chk(0, "after_b2b");

    xfer(0, 8'h12, 8'h12, 9, d);
    for (int i = 0; i < 5; i++) begin
      tick();
      idle_chk(0, $sformatf("after_inject%0d", i));
    end

    txb   = 8'h96;
    dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    repeat (7 * H - 1) tick();
    chk1("pre_reset_edge7_sclk", sclk0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("abort_sclk", sclk0, 1'b0);
    chk1("abort_ready", if0.o_tx_ready, 1'b1);
    chk8("abort_rxbyte", if0.o_rx_byte, 8'h00);
    chk1("abort_rxdv", if0.o_rx_dv, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_chk(0, $sformatf("post_abort%0d", i));
    end
    xfer(0, 8'hC3, 8'hC3, 0, d);
    tick();
    idle_chk(0, "after_c3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
